// File: rtl/loader_pkg.sv
// Shared types and frame constants for the imem boot loader.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
// Contents: state_t (loader FSM states), MAGIC_DEFAULT, LEN_W, CSUM_W,
//           in_frame() = true while the loader is inside a frame and waiting for bytes.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
   localparam int         LEN_W         = 16;   // word-count field
   localparam int         CSUM_W        = 8;    // checksum field

   // States in which the loader is part-way through a frame.
   function automatic logic in_frame(input state_t s);
      return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs four little-endian bytes into a 32-bit word for the imem write port.
// Latency: o_word_vld/o_word_dat register one cycle after the 4th byte; o_byte_last is combinational.
// Backpressure: none; accepts one byte per cycle indefinitely.
// Ports: i_clk, i_rst (sync, active-high), i_clr (restart clear), i_byte_vld/i_byte_dat (byte in),
//        o_byte_last (this byte completes a word), o_word_vld/o_word_dat (one-cycle word pulse).
module word_assembler (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_byte_vld,
   input  logic [7:0]  i_byte_dat,
   output logic        o_byte_last,
   output logic        o_word_vld,
   output logic [31:0] o_word_dat
);

   logic [1:0]  r_cnt;
   logic [23:0] r_shift;      // three most recent bytes, oldest in [7:0]
   logic        r_word_vld;
   logic [31:0] r_word;

   assign o_byte_last = i_byte_vld && (r_cnt == 2'd3);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt      <= 2'd0;
         r_shift    <= 24'd0;
         r_word_vld <= 1'b0;
         r_word     <= 32'd0;
      end else begin
         r_word_vld <= o_byte_last && !i_clr;
         if (i_clr) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
         end else if (i_byte_vld) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte_dat, r_shift[23:8]};
            // First byte received lands in bits 7:0 of the finished word.
            if (o_byte_last) begin
               r_word <= {i_byte_dat, r_shift};
            end
         end
      end
   end

   assign o_word_vld = r_word_vld;
   assign o_word_dat = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses MAGIC/LEN/data/CSUM frames from a byte stream, writes imem, releases the CPU.
// Latency: imem_we one cycle after the 4th byte of each word; status outputs one cycle after the deciding byte.
// Backpressure: none; a byte may arrive every cycle and none are dropped.
// Ports: sys_clk, sys_rst (sync, active-high); rx_data/rx_valid (byte stream in);
//        imem_we/imem_addr/imem_wdata (imem write port); cpu_rst_hold, load_done, load_err (status).
// Build option: define LOADER_TIMEOUT_EN to abort to ERR after TIMEOUT_CYC silent cycles inside a frame.
module imem_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_W      = 12,
   parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
   parameter int         TIMEOUT_CYC = 1000000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_hold,
   output logic              load_done,
   output logic              load_err
);

   // One extra bit so a full memory (N = 2^ADDR_W) counts without wrapping.
   localparam int IDX_W = ADDR_W + 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_restart;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    w_len_full;
   logic [IDX_W-1:0]    r_word_idx;
   logic [CSUM_W-1:0]   r_csum;
   logic [ADDR_W-1:0]   r_addr;
   logic                w_asm_vld;
   logic                w_byte_last;
   logic                w_idx_last;
   logic                w_word_vld;
   logic [31:0]         w_word_dat;
   logic                w_tmo_hit;

   assign w_len_full = {rx_data, r_len[7:0]};
   assign w_asm_vld  = rx_valid && (r_state == ST_DATA);
   assign w_idx_last = (32'(r_word_idx) + 32'd1) == 32'(r_len);

   word_assembler u_asm (
      .i_clk       (sys_clk),
      .i_rst       (sys_rst),
      .i_clr       (w_restart),
      .i_byte_vld  (w_asm_vld),
      .i_byte_dat  (rx_data),
      .o_byte_last (w_byte_last),
      .o_word_vld  (w_word_vld),
      .o_word_dat  (w_word_dat)
   );

`ifdef LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] r_tmo;

   // Counts silent cycles while inside a frame; any byte reloads it.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || rx_valid || !in_frame(r_state)) begin
         r_tmo <= '0;
      end else if (!w_tmo_hit) begin
         r_tmo <= r_tmo + TMO_W'(1);
      end
   end

   assign w_tmo_hit = in_frame(r_state) && !rx_valid && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYC == 0);
   assign w_tmo_hit    = 1'b0;
`endif

   // State register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; every transition is qualified by a received byte.
   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      if (rx_valid) begin
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (rx_data == MAGIC) begin
                  w_state_nxt = ST_LEN0;
                  w_restart   = 1'b1;
               end
            end
            ST_LEN0: w_state_nxt = ST_LEN1;
            ST_LEN1: begin
               if (32'(w_len_full) > (32'd1 << ADDR_W)) begin
                  w_state_nxt = ST_ERR;
               end else if (w_len_full == '0) begin
                  w_state_nxt = ST_CSUM;
               end else begin
                  w_state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_byte_last && w_idx_last) begin
                  w_state_nxt = ST_CSUM;
               end
            end
            ST_CSUM: begin
               w_state_nxt = (rx_data == r_csum) ? ST_DONE : ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
      if (w_tmo_hit) begin
         w_state_nxt = ST_ERR;
      end
   end

   // Frame datapath: length, word index, checksum and write address.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_len      <= '0;
         r_word_idx <= '0;
         r_csum     <= '0;
         r_addr     <= '0;
      end else if (w_restart) begin
         r_len      <= '0;
         r_word_idx <= '0;
         r_csum     <= '0;
      end else if (rx_valid) begin
         case (r_state)
            ST_LEN0: r_len[7:0]  <= rx_data;
            ST_LEN1: r_len[15:8] <= rx_data;
            ST_DATA: begin
               r_csum <= r_csum + rx_data;
               // Address is captured alongside the word so both appear in the write cycle.
               if (w_byte_last) begin
                  r_addr     <= r_word_idx[ADDR_W-1:0];
                  r_word_idx <= r_word_idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_we      = w_word_vld;
   assign imem_addr    = r_addr;
   assign imem_wdata   = w_word_dat;
   assign cpu_rst_hold = (r_state != ST_DONE);
   assign load_done    = (r_state == ST_DONE);
   assign load_err     = (r_state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int         AW    = 4;
   localparam logic [7:0] MAGIC = 8'hA5;

   logic          clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst_hold;
   logic          load_done;
   logic          load_err;

   imem_loader #(.ADDR_W(AW), .MAGIC(MAGIC), .TIMEOUT_CYC(100)) dut (
      .sys_clk      (clk),
      .sys_rst      (sys_rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_rst_hold (cpu_rst_hold),
      .load_done    (load_done),
      .load_err     (load_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic mon_en = 1'b0;

   always @(posedge clk) cyc++;

   // Expected imem writes: the cycle the pulse must be visible, address and word.
   typedef struct {
      int          due;
      int          addr;
      logic [31:0] data;
   } wr_t;
   wr_t expq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_wr(input int a, input logic [31:0] d);
      wr_t w;
      w.due  = cyc + 1;
      w.addr = a;
      w.data = d;
      expq.push_back(w);
   endtask

   // Per-cycle compare: imem_we must pulse exactly when the model says, otherwise stay low.
   always @(negedge clk) begin
      if (mon_en) begin
         if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("imem_we_pulse", 32'(imem_we), 32'd1);
            chk("imem_addr", 32'(imem_addr), 32'(expq[0].addr));
            chk("imem_wdata", imem_wdata, expq[0].data);
            void'(expq.pop_front());
         end else begin
            chk("imem_we_quiet", 32'(imem_we), 32'd0);
         end
         chk("hold_vs_done", 32'(cpu_rst_hold), 32'(!load_done));
         chk("done_err_excl", 32'(load_done & load_err), 32'd0);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'h00;
      end
   endtask

   task automatic chk_status(input string tag, input logic hold, input logic done, input logic err);
      chk({tag, "_hold"}, 32'(cpu_rst_hold), 32'(hold));
      chk({tag, "_done"}, 32'(load_done), 32'(done));
      chk({tag, "_err"}, 32'(load_err), 32'(err));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      sys_rst  = 1'b1;
      @(negedge clk);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk_status("rst", 1'b1, 1'b0, 1'b0);
      sys_rst = 1'b0;
   endtask

   // Hand-written two-word frame: A5 02 00 13 00 00 00 93 00 10 00 <csum>.
   task automatic send_two_word(input logic [7:0] csum, input bit pause_after_magic);
      logic [7:0] body [11];
      body = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00};
      for (int i = 0; i < 11; i++) begin
         send_byte(body[i]);
         if (i == 6)  push_wr(0, 32'h0000_0013);
         if (i == 10) push_wr(1, 32'h0010_0093);
         if (i == 0 && pause_after_magic) begin
            idle(1);
            chk_status("restart", 1'b1, 1'b0, 1'b0);
         end
      end
      send_byte(csum);
   endtask

   // Generic frame built from a word list; checksum computed from the words' bytes.
   task automatic send_load(input logic [31:0] words[$], input bit bad_csum, input bit gaps);
      logic [7:0] sum;
      logic [7:0] bt;
      int n;
      n   = words.size();
      sum = 8'h00;
      send_byte(MAGIC);
      send_byte(8'(n));
      send_byte(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 4; b++) begin
            bt  = words[i][8*b +: 8];
            sum = sum + bt;
            send_byte(bt);
            if (b == 3) push_wr(i, words[i]);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      send_byte(bad_csum ? sum + 8'h01 : sum);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] words[$];

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk_status("rst", 1'b1, 1'b0, 1'b0);
      mon_en  = 1'b1;
      sys_rst = 1'b0;

      // Good two-word image
      send_two_word(8'hB6, 1'b0);
      idle(1);
      chk_status("good2", 1'b0, 1'b1, 1'b0);

      // Restart from DONE, same image with bad checksum
      send_two_word(8'hB7, 1'b1);
      idle(1);
      chk_status("badcsum", 1'b1, 1'b0, 1'b1);

      // Noise in IDLE, then empty image
      do_reset();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
      idle(1);
      chk_status("noise", 1'b1, 1'b0, 1'b0);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      idle(1);
      chk_status("empty", 1'b0, 1'b1, 1'b0);

      // One-word image after DONE writes address 0
      words = '{32'hCAFE_F00D};
      send_load(words, 1'b0, 1'b0);
      idle(1);
      chk_status("oneword", 1'b0, 1'b1, 1'b0);

      // Length 17 exceeds 2^4 words: error right after LEN_HI, later bytes ignored
      send_byte(8'hA5); send_byte(8'h11); send_byte(8'h00);
      idle(1);
      chk_status("oversize", 1'b1, 1'b0, 1'b1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      idle(1);
      chk_status("oversize_hold", 1'b1, 1'b0, 1'b1);

      // Exactly 2^4 words fills memory without wrap, with random gaps
      words = {};
      for (int i = 0; i < 16; i++) words.push_back($urandom());
      send_load(words, 1'b0, 1'b1);
      idle(1);
      chk_status("full", 1'b0, 1'b1, 1'b0);

      // Reset in the middle of a three-word load after two words
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
      send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
      push_wr(0, 32'h1122_3344);
      send_byte(8'h88); send_byte(8'h77); send_byte(8'h66); send_byte(8'h55);
      push_wr(1, 32'h5566_7788);
      send_byte(8'h99);
      idle(1);
      do_reset();

      // Load after reset starts again at address 0
      words = '{32'h0000_0513};
      send_load(words, 1'b0, 1'b0);
      idle(1);
      chk_status("after_rst", 1'b0, 1'b1, 1'b0);

      // Stall after LEN_LO
      send_byte(8'hA5); send_byte(8'h01);
`ifdef LOADER_TIMEOUT_EN
      idle(100);
      chk_status("tmo_before", 1'b1, 1'b0, 1'b0);
      idle(1);
      chk_status("tmo_after", 1'b1, 1'b0, 1'b1);
`else
      idle(150);
      chk_status("no_tmo", 1'b1, 1'b0, 1'b0);
`endif

      idle(2);
      chk("writes_drained", 32'(expq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
